// File: rtl/seg_scan.sv
// Eight-digit time-multiplexed 7-segment driver for a common-anode display.
// Inputs are captured once per frame so a digit never changes mid-frame.
module seg_scan #(
  parameter int DIV = 100000,
  parameter int CW  = 17
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] data,
  input  logic [7:0]  dmask,
  input  logic [7:0]  dpm,
  input  logic        lzb,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  logic [CW-1:0] cnt_reg;
  logic [2:0]    idx_reg;
  logic [31:0]   data_reg;
  logic [7:0]    mask_reg;
  logic [7:0]    dpm_reg;
  logic          lzb_reg;
  logic          frame_reg;
  logic [7:0]    an_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;

  logic          tick;
  logic          snap;
  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  logic [7:0]    nz;
  logic [7:1]    hi_zero;
  logic [7:0]    blank_vec;

  assign tick = (cnt_reg == CW'(DIV - 1));
  assign snap = tick && (idx_reg == 3'd7);

  // hi_zero[i]: nibbles i..7 of the snapshot are all zero (digit 0 is never zero-blanked)
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nz
      assign nz[gi] = |data_reg[4*gi +: 4];
    end
    for (genvar gi = 1; gi < 8; gi++) begin : g_hz
      if (gi == 7) begin : g_top
        assign hi_zero[gi] = ~nz[gi];
      end else begin : g_mid
        assign hi_zero[gi] = ~nz[gi] & hi_zero[gi+1];
      end
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_blank
      if (gi == 0) begin : g_d0
        assign blank_vec[gi] = ~mask_reg[gi];
      end else begin : g_dn
        assign blank_vec[gi] = ~mask_reg[gi] | (lzb_reg & hi_zero[gi]);
      end
    end
  endgenerate

  assign nib = data_reg[{idx_reg, 2'b00} +: 4];

  always_comb begin
    seg_dec = 7'h7F;
    case (nib)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      4'hF: seg_dec = 7'b0001110;
      default: seg_dec = 7'h7F;
    endcase
  end

  always_comb begin
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (!blank_vec[idx_reg]) begin
      an_next  = ~(8'b1 << idx_reg);
      seg_next = seg_dec;
      dp_next  = ~dpm_reg[idx_reg];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg   <= '0;
      idx_reg   <= 3'd0;
      data_reg  <= 32'h0;
      mask_reg  <= 8'h00;
      dpm_reg   <= 8'h00;
      lzb_reg   <= 1'b0;
      frame_reg <= 1'b0;
      an_reg    <= 8'hFF;
      seg_reg   <= 7'h7F;
      dp_reg    <= 1'b1;
    end else begin
      cnt_reg   <= tick ? '0 : cnt_reg + CW'(1);
      if (tick) begin
        idx_reg <= idx_reg + 3'd1;
      end
      frame_reg <= snap;
      // Snapshot shares the edge where idx wraps 7->0
      if (snap) begin
        data_reg <= data;
        mask_reg <= dmask;
        dpm_reg  <= dpm;
        lzb_reg  <= lzb;
      end
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign an    = an_reg;
  assign seg   = seg_reg;
  assign dp    = dp_reg;
  assign frame = frame_reg;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: table of per-frame vectors scored through
// an expected-digit queue, plus tearing and asynchronous-reset sequences.
module tb_seg_scan;
  localparam int DIV = 4;
  localparam int CW  = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] data = 32'h0;
  logic [7:0]  dmask = 8'h00;
  logic [7:0]  dpm = 8'h00;
  logic        lzb = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  seg_scan #(.DIV(DIV), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .data(data), .dmask(dmask), .dpm(dpm), .lzb(lzb),
    .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dmask;
    logic [7:0]  dpm;
    logic        lzb;
    logic [7:0]  exp_lit;
    logic [7:0]  exp_dp;
  } vec_t;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  vec_t vecs [8];
  exp_t sb_q [$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [7:0] lit, input logic [7:0] dpl);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.an  = lit[i] ? ~(8'b1 << i) : 8'hFF;
      e.seg = lit[i] ? hexseg(d[4*i +: 4]) : 7'h7F;
      e.dp  = lit[i] ? ~dpl[i] : 1'b1;
      sb_q.push_back(e);
    end
  endtask

  task automatic apply(input vec_t v);
    data = v.data; dmask = v.dmask; dpm = v.dpm; lzb = v.lzb;
  endtask

  // Runs n clocks starting just after a snapshot edge; digit k/4 is shown on clock k.
  task automatic run_frame(input string tag, input int n, input bit chg_en,
                           input int chg_at, input logic [31:0] chg_data);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL %s scoreboard empty at k=%0d: got an=%h seg=%b", tag, k, an, seg);
      end else begin
        e = sb_q[0];
        check($sformatf("%s d%0d k%0d an/seg/dp", tag, k/4, k),
              {16'h0, an, seg, dp}, {16'h0, e.an, e.seg, e.dp});
        if (k % 4 == 3) e = sb_q.pop_front();
      end
      check($sformatf("%s k%0d frame", tag, k), {31'h0, frame}, {31'h0, (k == 31)});
      if (chg_en && k == chg_at) data = chg_data;
    end
    $display("frame %s: %0d clocks scored, data_in=%h", tag, n, data);
  endtask

  // After reset release: 32 dark clocks, frame pulse only on the 32nd.
  task automatic dark_frame(input string tag);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      check($sformatf("%s k%0d dark", tag, k), {16'h0, an, seg, dp}, {16'h0, 8'hFF, 7'h7F, 1'b1});
      check($sformatf("%s k%0d frame", tag, k), {31'h0, frame}, {31'h0, (k == 32)});
    end
    $display("frame %s: dark frame scored", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h89ABCDEF, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00};
    vecs[1] = '{32'h00000120, 8'hFF, 8'h00, 1'b1, 8'h07, 8'h00};
    vecs[2] = '{32'h00000000, 8'hFF, 8'h00, 1'b1, 8'h01, 8'h00};
    vecs[3] = '{32'h00000321, 8'h05, 8'h04, 1'b0, 8'h05, 8'h04};
    vecs[4] = '{32'h00000000, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00};
    vecs[5] = '{32'hF0000000, 8'h7F, 8'hFF, 1'b1, 8'h7F, 8'h7F};
    vecs[6] = '{32'h01000000, 8'hFF, 8'h81, 1'b1, 8'h7F, 8'h01};
    vecs[7] = '{32'h10203005, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00};

    // Reset held across clock edges
    apply(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    check("reset an", {24'h0, an}, 32'hFF);
    check("reset seg", {25'h0, seg}, 32'h7F);
    check("reset dp", {31'h0, dp}, 32'h1);
    check("reset frame", {31'h0, frame}, 32'h0);
    @(negedge clk) rstn = 1'b1;
    dark_frame("boot");

    // Table: vector v captured at the boundary just passed; v+1 driven mid-frame
    for (int v = 0; v < 8; v++) begin
      push_frame(vecs[v].data, vecs[v].exp_lit, vecs[v].exp_dp);
      if (v < 7) apply(vecs[v+1]);
      else data = 32'h11111111;
      run_frame($sformatf("vec%0d", v), 32, 1'b0, 0, 32'h0);
    end
    // vecs[7] mask/dpm/lzb stay; data 1s captured. Change to 2s while idx==3.
    lzb = 1'b0;
    push_frame(32'h11111111, 8'hFF, 8'h00);
    run_frame("tear_ones", 32, 1'b1, 13, 32'h22222222);
    push_frame(32'h22222222, 8'hFF, 8'h00);
    run_frame("tear_twos", 32, 1'b0, 0, 32'h0);

    // Async reset while idx==5, between clock edges
    push_frame(32'h22222222, 8'hFF, 8'h00);
    run_frame("pre_rst", 22, 1'b0, 0, 32'h0);
    #2 rstn = 1'b0;
    #1;
    check("async rst an", {24'h0, an}, 32'hFF);
    check("async rst seg", {25'h0, seg}, 32'h7F);
    check("async rst dp", {31'h0, dp}, 32'h1);
    check("async rst frame", {31'h0, frame}, 32'h0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    dark_frame("post_rst");
    push_frame(32'h22222222, 8'hFF, 8'h00);
    run_frame("post_rst_twos", 32, 1'b0, 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Reader/display end of the switch-loaded operand/result path: takes a 32-bit hex word (e.g. {a, b, f, y} packed by the top level) and drives an 8-digit common-anode 7-segment display by time-multiplexing.
- Snapshots its inputs once per frame so a digit never changes mid-frame, and supports per-digit enable, decimal points and leading-zero blanking.
- Sits between the top-level register set and board pins an/seg/dp.

Parameters:
- DIV, 100000, clocks per digit slot (scan prescaler); legal range >= 2.
- CW, 17, prescaler counter width; must satisfy 2^CW >= DIV.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- data  input  32  hex value; nibble i (data[4i+3:4i]) shown on digit i.
- dmask  input  8  digit enable; bit i = 1 lights digit i.
- dpm  input  8  decimal point; bit i = 1 lights dp on digit i.
- lzb  input  1  leading-zero blanking enable.
- an  output  8  digit anodes, active-low, at most one bit low.
- seg  output  7  segments {g,f,e,d,c,b,a}, seg[0]=a, active-low.
- dp  output  1  decimal point, active-low.
- frame  output  1  one-clock pulse on each frame boundary (snapshot taken).

Behaviour:
- Reset (rstn=0, asynchronous, immediate): cnt=0, idx=0, data_q=0, mask_q=0, dpm_q=0, lzb_q=0, an=8'hFF, seg=7'h7F, dp=1, frame=0.
- Prescaler: cnt counts 0..DIV-1 and wraps; tick = (cnt==DIV-1).
- Digit index: idx (3 bits) increments on tick and wraps 7->0.
- Snapshot: on the tick where idx==7, on the same edge as idx->0, load data_q<=data, mask_q<=dmask, dpm_q<=dpm, lzb_q<=lzb, and frame<=1 for exactly one clock. Inputs are ignored at all other times.
- Consequence: the display is dark for the first frame after reset (8*DIV clocks) until the first snapshot.
- Output stage: an/seg/dp are registered from (idx, snapshot), so they lag an idx change by one clock.
- Digit i is blank if mask_q[i]==0, or if lzb_q==1, i!=0, and nibbles i..7 of data_q are all zero. Digit 0 is never zero-blanked.
- Lit digit: an = ~(8'b1<<idx); seg = hex decode of nibble idx; dp = ~dpm_q[idx].
- Blank digit: an=8'hFF, seg=7'h7F, dp=1.
- Decode table, seg as {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Input changes mid-frame have no visible effect until the next frame boundary. An input change on the exact snapshot edge is captured.
- Reset mid-scan: outputs go blank immediately, and scanning restarts from idx=0 with cnt=0 after rstn deasserts.
- No combinational path from any input to any output.

Test Plan:
- Reset: rstn=0 held, then released; DIV=4 -> an=FF, seg=7F, dp=1, frame=0 for the first 32 clocks; frame pulses at clock 32.
- Scan: DIV=4, data=32'h89ABCDEF, dmask=FF, lzb=0 -> second frame shows an=FE seg=0001110 (F), then an=FD seg=0000110 (E), ..., an=7F seg=0000000 (8); each digit held 4 clocks; frame pulse every 32 clocks.
- Blanking: data=32'h00000120, dmask=FF, lzb=1 -> digits 0..2 show 0,2,1; digits 3..7 an=FF. data=0 -> only digit 0 lit, showing 0.
- Mask/dp: dmask=8'h05, dpm=8'h04, data=32'h00000321 -> only digits 0 (1) and 2 (3) lit; dp=0 only during digit 2.
- Tearing: change data from 32'h11111111 to 32'h22222222 while idx=3 -> the rest of that frame still shows 1; the next frame shows 2.
- Async reset mid-scan: pull rstn low while idx=5 between clock edges -> an=FF immediately (no clock edge needed); after release, the first tick advances idx 0->1.
